// File: rtl/alu_pkg.sv
// Shared types and opcode helpers for the sequential RV32M multiply/divide unit.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return op[2];
   endfunction

   function automatic logic is_rem(input muldiv_op_e op);
      return op[2] & op[1];
   endfunction

   function automatic logic opr1_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic opr2_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring compare-subtract divide
// over a {hi, lo} register pair.
module muldiv_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opb,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Multiply: lo holds the remaining multiplier bits, product grows into hi from the top.
   // Divide: lo holds dividend bits shifting out / quotient bits shifting in, hi the partial remainder.
   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, opb};
      hi_nxt  = sum[XLEN:1];
      lo_nxt  = {sum[0], lo[XLEN-1:1]};
      if (is_div) begin
         hi_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
         lo_nxt = {lo[XLEN-2:0], ~diff[XLEN]};
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshakes, flush and
// early resolution of divide-by-zero and signed-overflow cases.
import alu_pkg::*;

module alu_muldiv_seq #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] opr1,
   input  logic [XLEN-1:0] opr2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int unsigned STEPS = XLEN / UNROLL;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e   state_q;
   logic [CNT_W-1:0] cnt_q;
   muldiv_op_e      op_q;
   logic [XLEN-1:0] hi_q, lo_q, opb_q;
   logic            neg_q, neg_rem_q;
   logic [XLEN-1:0] result_q;

   muldiv_op_e      op_in;
   logic            s1, s2;
   logic [XLEN-1:0] mag1, mag2;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] special_res;

   always_comb begin
      op_in       = muldiv_op_e'(op);
      s1          = opr1_signed(op_in) & opr1[XLEN-1];
      s2          = opr2_signed(op_in) & opr2[XLEN-1];
      mag1        = s1 ? ('0 - opr1) : opr1;
      mag2        = s2 ? ('0 - opr2) : opr2;
      div_zero    = is_div(op_in) && (opr2 == '0);
      div_ovf     = is_div(op_in) && opr2_signed(op_in) && (opr1 == MIN_INT) && (opr2 == '1);
      special_res = '0;
      if (div_zero)
         special_res = is_rem(op_in) ? opr1 : '1;
      else if (div_ovf)
         special_res = is_rem(op_in) ? '0 : MIN_INT;
   end

   logic [UNROLL:0][XLEN-1:0] hi_c, lo_c;
   logic                      op_is_div;

   assign op_is_div = is_div(op_q);
   assign hi_c[0]   = hi_q;
   assign lo_c[0]   = lo_q;

   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div (op_is_div),
         .hi     (hi_c[g]),
         .lo     (lo_c[g]),
         .opb    (opb_q),
         .hi_nxt (hi_c[g+1]),
         .lo_nxt (lo_c[g+1])
      );
   end

   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   // Work was done on magnitudes; signs are restored here in one place.
   always_comb begin
      prod    = {hi_q, lo_q};
      prod_s  = neg_q ? ('0 - prod) : prod;
      quo_s   = neg_q ? ('0 - lo_q) : lo_q;
      rem_s   = neg_rem_q ? ('0 - hi_q) : hi_q;
      fix_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      if (op_is_div)
         fix_res = op_q[1] ? rem_s : quo_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= OP_MUL;
         hi_q      <= '0;
         lo_q      <= '0;
         opb_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && !flush) begin
                  op_q      <= op_in;
                  hi_q      <= '0;
                  lo_q      <= mag1;
                  opb_q     <= mag2;
                  neg_q     <= s1 ^ s2;
                  neg_rem_q <= s1;
                  cnt_q     <= '0;
                  if (div_zero || div_ovf) begin
                     result_q <= special_res;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  hi_q  <= hi_c[UNROLL];
                  lo_q  <= lo_c[UNROLL];
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST)
                     state_q <= FIX;
               end
            end
            FIX: begin
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= fix_res;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               if (flush || out_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;

endmodule
